// File: rtl/reg_file_pkg.sv
// Shared defaults and data types for the scoreboarded register file.
package reg_file_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int NUM_REGS_DEF  = 32;
    localparam int ADDR_SIZE_DEF = 5;
    localparam int NUM_READ_DEF  = 2;

    typedef logic [ADDR_SIZE_DEF-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]      reg_data_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Writeback / issue / read bus of the scoreboarded register file.
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int NUM_READ  = NUM_READ_DEF
) ();

    logic                                 write_en;
    logic [ADDR_SIZE-1:0]                 write_addr;
    logic [XLEN-1:0]                      write_data;
    logic                                 issue_en;
    logic [ADDR_SIZE-1:0]                 issue_addr;
    logic [NUM_READ-1:0]                  read_en;
    logic [NUM_READ-1:0][ADDR_SIZE-1:0]   read_addr;
    logic [NUM_READ-1:0][XLEN-1:0]        read_data;
    logic [NUM_READ-1:0]                  read_busy;
    logic [NUM_REGS-1:0]                  busy_vec;

    modport master (
        output write_en, write_addr, write_data,
        output issue_en, issue_addr,
        output read_en, read_addr,
        input  read_data, read_busy, busy_vec
    );

    modport slave (
        input  write_en, write_addr, write_data,
        input  issue_en, issue_addr,
        input  read_en, read_addr,
        output read_data, read_busy, busy_vec
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-destination bits: issue sets, writeback clears, issue wins a tie.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_write_en,
    input  logic [ADDR_SIZE-1:0] i_write_addr,
    input  logic                 i_issue_en,
    input  logic [ADDR_SIZE-1:0] i_issue_addr,
    output logic [NUM_REGS-1:0]  o_busy_vec
);

    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] LP_NUM_REGS = (ADDR_SIZE + 1)'(NUM_REGS);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic             w_wr_ok;
    logic             w_iss_ok;

    assign w_wr_ok  = i_write_en && (i_write_addr != '0) &&
                      ({1'b0, i_write_addr} < LP_NUM_REGS);
    assign w_iss_ok = i_issue_en && (i_issue_addr != '0) &&
                      ({1'b0, i_issue_addr} < LP_NUM_REGS);

    // Next busy state: clear on writeback first, then set on issue so a new producer wins
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_ok) begin
            w_busy_next[i_write_addr] = 1'b0;
        end
        if (w_iss_ok) begin
            w_busy_next[i_issue_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Busy register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy_vec = r_busy[NUM_REGS-1:0];

endmodule

// File: rtl/reg_file_sb.sv
// Flop-based register file with write-first forwarding and a pending scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int NUM_READ  = NUM_READ_DEF
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);

    // Storage is sized to the full address space so any address indexes cleanly;
    // entries at or above NUM_REGS (and entry 0) are never written and stay zero.
    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] LP_NUM_REGS = (ADDR_SIZE + 1)'(NUM_REGS);

    logic [DEPTH-1:0][XLEN-1:0]     r_regs;
    logic [NUM_READ-1:0][XLEN-1:0]  r_read_data;
    logic [NUM_READ-1:0]            r_read_busy;
    logic [NUM_READ-1:0][XLEN-1:0]  w_rd_data;
    logic [NUM_READ-1:0]            w_rd_busy;
    logic [NUM_REGS-1:0]            w_busy_vec;
    logic [DEPTH-1:0]               w_busy_ext;
    logic                           w_wr_ok;

    assign w_wr_ok = bus.write_en && (bus.write_addr != '0) &&
                     ({1'b0, bus.write_addr} < LP_NUM_REGS);

    reg_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_write_en   (bus.write_en),
        .i_write_addr (bus.write_addr),
        .i_issue_en   (bus.issue_en),
        .i_issue_addr (bus.issue_addr),
        .o_busy_vec   (w_busy_vec)
    );

    // Architectural register storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '0;
        end else if (w_wr_ok) begin
            r_regs[bus.write_addr] <= bus.write_data;
        end
    end

    // Per-port read lookup; a same-cycle writeback forwards its data and reads as not busy
    always_comb begin
        w_busy_ext                 = '0;
        w_busy_ext[NUM_REGS-1:0]   = w_busy_vec;
        for (int unsigned p = 0; p < NUM_READ; p++) begin
            w_rd_data[p] = '0;
            w_rd_busy[p] = 1'b0;
            if ((bus.read_addr[p] != '0) && ({1'b0, bus.read_addr[p]} < LP_NUM_REGS)) begin
                if (w_wr_ok && (bus.write_addr == bus.read_addr[p])) begin
                    w_rd_data[p] = bus.write_data;
                end else begin
                    w_rd_data[p] = r_regs[bus.read_addr[p]];
                    w_rd_busy[p] = w_busy_ext[bus.read_addr[p]];
                end
            end
        end
    end

    // Registered read outputs, held while the port's strobe is low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_data <= '0;
            r_read_busy <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_READ; p++) begin
                if (bus.read_en[p]) begin
                    r_read_data[p] <= w_rd_data[p];
                    r_read_busy[p] <= w_rd_busy[p];
                end
            end
        end
    end

    assign bus.read_data = r_read_data;
    assign bus.read_busy = r_read_busy;
    assign bus.busy_vec  = w_busy_vec;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed scenarios then random traffic.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int NR = 24;   // fewer registers than addresses, so out-of-range is reachable

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  rb;
        logic [NR-1:0] bv;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t expq[$];

    // Reference model state
    logic [31:0] m_regs [NR];
    bit          m_busy [NR];
    logic [31:0] m_rd   [2];
    bit          m_rb   [2];

    reg_file_sb_if #(.XLEN(32), .NUM_REGS(NR), .ADDR_SIZE(5), .NUM_READ(2)) bus ();

    reg_file_sb #(.XLEN(32), .NUM_REGS(NR), .ADDR_SIZE(5), .NUM_READ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic bit valid_addr(input int a);
        return (a != 0) && (a < NR);
    endfunction

    task automatic drive(input bit r, input bit we, input int wa, input logic [31:0] wd,
                         input bit ie, input int ia, input bit re0, input int ra0,
                         input bit re1, input int ra1);
        exp_t e;
        int   ra [2];
        bit   re [2];
        @(negedge clk);
        rst            = r;
        bus.write_en   = we;
        bus.write_addr = 5'(wa);
        bus.write_data = wd;
        bus.issue_en   = ie;
        bus.issue_addr = 5'(ia);
        bus.read_en    = {re1, re0};
        bus.read_addr[0] = 5'(ra0);
        bus.read_addr[1] = 5'(ra1);
        ra[0] = ra0; ra[1] = ra1; re[0] = re0; re[1] = re1;
        if (r) begin
            for (int i = 0; i < NR; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
            for (int p = 0; p < 2; p++) begin m_rd[p] = 0; m_rb[p] = 0; end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (re[p]) begin
                    if (!valid_addr(ra[p])) begin m_rd[p] = 0; m_rb[p] = 0; end
                    else if (we && wa == ra[p]) begin m_rd[p] = wd; m_rb[p] = 0; end
                    else begin m_rd[p] = m_regs[ra[p]]; m_rb[p] = m_busy[ra[p]]; end
                end
            end
            if (we && valid_addr(wa)) begin m_regs[wa] = wd; m_busy[wa] = 0; end
            if (ie && valid_addr(ia)) m_busy[ia] = 1;
        end
        e.rd0 = m_rd[0];
        e.rd1 = m_rd[1];
        e.rb  = {m_rb[1], m_rb[0]};
        for (int i = 0; i < NR; i++) e.bv[i] = m_busy[i];
        expq.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one expected response per driven cycle, compared after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                checks++;
                if (bus.read_data[0] !== e.rd0) begin
                    errors++;
                    $display("FAIL read_data0 cyc=%0d got=%h exp=%h", cyc, bus.read_data[0], e.rd0);
                end
                checks++;
                if (bus.read_data[1] !== e.rd1) begin
                    errors++;
                    $display("FAIL read_data1 cyc=%0d got=%h exp=%h", cyc, bus.read_data[1], e.rd1);
                end
                checks++;
                if (bus.read_busy !== e.rb) begin
                    errors++;
                    $display("FAIL read_busy cyc=%0d got=%b exp=%b", cyc, bus.read_busy, e.rb);
                end
                checks++;
                if (bus.busy_vec !== e.bv) begin
                    errors++;
                    $display("FAIL busy_vec cyc=%0d got=%h exp=%h", cyc, bus.busy_vec, e.bv);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.write_en = 0; bus.write_addr = '0; bus.write_data = '0;
        bus.issue_en = 0; bus.issue_addr = '0;
        bus.read_en = '0; bus.read_addr = '0;

        // Reset, then write x5 and read it on both ports
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 5, 1, 5);
        idle();
        // x0 is hardwired
        drive(0, 1, 0, 32'h1234, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        // Forwarding
        drive(0, 1, 7, 32'hA5A5A5A5, 0, 0, 1, 7, 0, 0);
        idle();
        // Busy tracking on x3
        drive(0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 3, 1, 3);
        drive(0, 1, 3, 32'h55, 0, 0, 1, 3, 0, 0);
        drive(0, 1, 3, 32'h66, 1, 3, 0, 0, 1, 3);
        drive(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        // Reset overrides write/read with x9 busy
        drive(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 9, 1, 9, 0, 0);
        drive(1, 1, 9, 32'h1111, 1, 9, 1, 9, 1, 9);
        drive(0, 0, 0, 0, 0, 0, 1, 9, 1, 9);
        // Hold behaviour
        drive(0, 1, 10, 32'h77, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 10, 1, 10);
        idle(); idle(); idle();
        // Out-of-range addresses
        drive(0, 1, 30, 32'hBAD, 1, 25, 1, 30, 1, 24);
        drive(0, 1, 23, 32'h2323, 1, 23, 1, 23, 1, 31);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 49) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 31), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 31),
                  $urandom_range(0, 1), $urandom_range(0, 31),
                  $urandom_range(0, 1), $urandom_range(0, 31));
        end
        idle();
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
